h2c_receiver: RTL and testbench

Host-to-card AXI4-Stream receiver for the XDMA H2C channel: accepts beats from `s_axis_h2c_*`, writes them into the input FIFO that feeds the processing core, counts beats per frame (delimited by `tlast`), and presents a frame-complete indication with length and status to the core.
- Counterpart of the C2H feedback path.
- The core consumes FIFO data and acknowledges the frame before the next frame is admitted.

---
 rtl/h2c_receiver.sv | 113 +++++++++++
 tb/tb_h2c_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h2c_receiver.sv
// h2c_receiver: XDMA host-to-card AXI4-Stream receiver.
// Writes accepted beats straight into the core's input FIFO, counts beats per
// frame, truncates frames longer than MAX_BEATS, and holds a frame-complete
// indication (length, last-beat keep, error) until the core acknowledges it.
// Optional feature: define H2C_KEEP_CHECK_EN to flag partial tkeep on non-last beats.
module h2c_receiver #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_BEATS  = 4096
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_h2c_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_h2c_tkeep,
  input  logic                  s_axis_h2c_tlast,
  input  logic                  s_axis_h2c_tvalid,
  output logic                  s_axis_h2c_tready,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic [KEEP_WIDTH-1:0] frame_keep,
  output logic                  frame_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BEATS);

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 writing;
  logic                 accept;
  logic                 keep_bad;

  // Ready depends only on state and FIFO backpressure; held low while in reset.
  always_comb begin
    s_axis_h2c_tready = 1'b0;
    case (state)
      IDLE, RECV: s_axis_h2c_tready = !fifo_full;
      DROP:       s_axis_h2c_tready = 1'b1;
      default:    s_axis_h2c_tready = 1'b0;
    endcase
    if (user_rst) s_axis_h2c_tready = 1'b0;
  end

  assign writing     = (state == IDLE) || (state == RECV);
  assign accept      = s_axis_h2c_tvalid & s_axis_h2c_tready;
  assign fifo_wr_en  = accept & writing;
  assign fifo_din    = s_axis_h2c_tdata;
  assign cnt_inc     = cnt + 1'b1;
  assign frame_valid = (state == DONE);

`ifdef H2C_KEEP_CHECK_EN
  assign keep_bad = fifo_wr_en & !s_axis_h2c_tlast & (s_axis_h2c_tkeep != '1);
`else
  assign keep_bad = 1'b0;
`endif

  // Frame FSM: IDLE and RECV share one path since cnt is zero in IDLE.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_len  <= '0;
      frame_keep <= '1;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, RECV: begin
          if (fifo_wr_en) begin
            if (keep_bad) frame_err <= 1'b1;
            if (s_axis_h2c_tlast) begin
              state      <= DONE;
              frame_len  <= cnt_inc;
              frame_keep <= s_axis_h2c_tkeep;
            end else if (cnt_inc == MAX_LEN) begin
              // Last beat that fits: keep it, discard the rest of the frame.
              state     <= DROP;
              cnt       <= cnt_inc;
              frame_len <= MAX_LEN;
              frame_err <= 1'b1;
            end else begin
              state <= RECV;
              cnt   <= cnt_inc;
            end
          end
        end
        DROP: begin
          if (accept && s_axis_h2c_tlast) begin
            state      <= DONE;
            frame_keep <= s_axis_h2c_tkeep;
          end
        end
        default: begin
          if (frame_ack) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h2c_receiver.sv
// tb_h2c_receiver: directed bench for h2c_receiver. Two instances share the
// stream inputs: one with default MAX_BEATS, one with MAX_BEATS=4 for overflow.
module tb_h2c_receiver;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  tdata;
  logic [15:0]   tkeep;
  logic          tlast, tvalid, fifo_full, frame_ack;

  logic          tready_a, wr_a, valid_a, err_a;
  logic [127:0]  din_a;
  logic [31:0]   len_a;
  logic [15:0]   keep_a;
  logic          tready_b, wr_b, valid_b, err_b;
  logic [127:0]  din_b;
  logic [31:0]   len_b;
  logic [15:0]   keep_b;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  logic [127:0] mem_a [0:255];

`ifdef H2C_KEEP_CHECK_EN
  localparam logic KEEP_ERR_EXP = 1'b1;
`else
  localparam logic KEEP_ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  h2c_receiver dut (
    .user_clk(clk), .user_rst(rst),
    .s_axis_h2c_tdata(tdata), .s_axis_h2c_tkeep(tkeep), .s_axis_h2c_tlast(tlast),
    .s_axis_h2c_tvalid(tvalid), .s_axis_h2c_tready(tready_a),
    .fifo_din(din_a), .fifo_wr_en(wr_a), .fifo_full(fifo_full),
    .frame_valid(valid_a), .frame_ack(frame_ack), .frame_len(len_a),
    .frame_keep(keep_a), .frame_err(err_a)
  );

  h2c_receiver #(.MAX_BEATS(4)) dut_m4 (
    .user_clk(clk), .user_rst(rst),
    .s_axis_h2c_tdata(tdata), .s_axis_h2c_tkeep(tkeep), .s_axis_h2c_tlast(tlast),
    .s_axis_h2c_tvalid(tvalid), .s_axis_h2c_tready(tready_b),
    .fifo_din(din_b), .fifo_wr_en(wr_b), .fifo_full(fifo_full),
    .frame_valid(valid_b), .frame_ack(frame_ack), .frame_len(len_b),
    .frame_keep(keep_b), .frame_err(err_b)
  );

  // Record every FIFO write (inputs change just after posedge, so negedge is stable).
  always @(negedge clk) begin
    if (wr_a) begin
      mem_a[wr_cnt_a[7:0]] <= din_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (wr_b) wr_cnt_b <= wr_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int fid, input int b);
    return {fid[31:0], 64'hA5A5_5A5A_0123_4567, b[31:0]};
  endfunction

  // Present one beat and hold it until the default instance accepts it.
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n = 0;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    @(negedge clk);
    while (!tready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tready_a) check("beat_timeout", tready_a, 1'b1);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  int base_a, base_b;

  initial begin
    rst = 1'b1; tdata = '0; tkeep = '1; tlast = 1'b0; tvalid = 1'b0;
    fifo_full = 1'b0; frame_ack = 1'b0;

    // Reset state
    @(posedge clk); #1;
    tvalid = 1'b1;
    @(negedge clk);
    check("rst_tready", tready_a, 1'b0);
    check("rst_wr_en", wr_a, 1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_len", len_a, 32'd0);
    check("rst_keep", keep_a, 16'hFFFF);
    check("rst_err", err_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; tvalid = 1'b0;
    @(negedge clk);
    check("post_rst_tready", tready_a, 1'b1);
    @(posedge clk); #1;

    // 4-beat frame, last keep 00FF
    base_a = wr_cnt_a;
    for (int i = 1; i <= 4; i++) send_beat(mk(1, i), (i == 4) ? 16'h00FF : 16'hFFFF, i == 4);
    @(negedge clk);
    check("f4_valid", valid_a, 1'b1);
    check("f4_len", len_a, 32'd4);
    check("f4_keep", keep_a, 16'h00FF);
    check("f4_err", err_a, 1'b0);
    check("f4_writes", wr_cnt_a - base_a, 4);
    check("f4_done_tready", tready_a, 1'b0);
    check("f4_m4_len", len_b, 32'd4);
    check("f4_m4_err", err_b, 1'b0);
    ack();
    @(negedge clk);
    check("f4_ack_valid", valid_a, 1'b0);
    check("f4_ack_tready", tready_a, 1'b1);
    @(posedge clk); #1;

    // Single-beat frame, then a second frame offered before ack
    send_beat(mk(2, 1), 16'hFFFF, 1'b1);
    @(negedge clk);
    check("f1_len", len_a, 32'd1);
    check("f1_valid", valid_a, 1'b1);
    @(posedge clk); #1;
    tdata = mk(3, 1); tkeep = 16'h000F; tlast = 1'b1; tvalid = 1'b1;
    base_a = wr_cnt_a;
    @(negedge clk);
    check("pre_ack_tready0", tready_a, 1'b0);
    @(negedge clk);
    check("pre_ack_tready1", tready_a, 1'b0);
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(negedge clk);
    check("ack_cycle_tready", tready_a, 1'b0);
    @(posedge clk); #1;
    frame_ack = 1'b0;
    @(negedge clk);
    check("after_ack_tready", tready_a, 1'b1);
    check("after_ack_wr", wr_a, 1'b1);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    check("f1b_valid", valid_a, 1'b1);
    check("f1b_len", len_a, 32'd1);
    check("f1b_keep", keep_a, 16'h000F);
    check("f1b_writes", wr_cnt_a - base_a, 1);
    ack();

    // 8-beat frame, fifo_full for 3 cycles during beat 5
    base_a = wr_cnt_a;
    for (int i = 1; i <= 4; i++) send_beat(mk(4, i), 16'hFFFF, 1'b0);
    tdata = mk(4, 5); tkeep = 16'hFFFF; tlast = 1'b0; tvalid = 1'b1; fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_tready", tready_a, 1'b0);
      check("stall_wr", wr_a, 1'b0);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    for (int i = 5; i <= 8; i++) send_beat(mk(4, i), 16'hFFFF, i == 8);
    @(negedge clk);
    check("f8_valid", valid_a, 1'b1);
    check("f8_len", len_a, 32'd8);
    check("f8_writes", wr_cnt_a - base_a, 8);
    for (int i = 0; i < 8; i++) check("f8_data", mem_a[(base_a + i) % 256], mk(4, i + 1));
    ack();

    // Overflow on MAX_BEATS=4 instance with a 10-beat frame
    base_a = wr_cnt_a;
    base_b = wr_cnt_b;
    for (int i = 1; i <= 4; i++) send_beat(mk(5, i), 16'hFFFF, 1'b0);
    for (int i = 5; i <= 10; i++) begin
      tdata = mk(5, i); tkeep = (i == 10) ? 16'h0003 : 16'hFFFF; tlast = (i == 10); tvalid = 1'b1;
      @(negedge clk);
      check("drop_tready", tready_b, 1'b1);
      check("drop_wr", wr_b, 1'b0);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    check("ovf_valid", valid_b, 1'b1);
    check("ovf_len", len_b, 32'd4);
    check("ovf_err", err_b, 1'b1);
    check("ovf_keep", keep_b, 16'h0003);
    check("ovf_writes", wr_cnt_b - base_b, 4);
    check("f10_len", len_a, 32'd10);
    check("f10_err", err_a, 1'b0);
    check("f10_writes", wr_cnt_a - base_a, 10);
    ack();
    @(negedge clk);
    check("ovf_err_clr", err_b, 1'b0);
    @(posedge clk); #1;

    // Reset at beat 3 of 6, remaining beats form a new frame
    send_beat(mk(6, 1), 16'hFFFF, 1'b0);
    send_beat(mk(6, 2), 16'hFFFF, 1'b0);
    tdata = mk(6, 3); tkeep = 16'hFFFF; tvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("midrst_tready", tready_a, 1'b0);
    check("midrst_wr", wr_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; tvalid = 1'b0;
    @(negedge clk);
    check("midrst_valid", valid_a, 1'b0);
    check("midrst_len", len_a, 32'd0);
    check("midrst_keep", keep_a, 16'hFFFF);
    check("midrst_err", err_a, 1'b0);
    check("midrst_tready_idle", tready_a, 1'b1);
    @(posedge clk); #1;
    for (int i = 4; i <= 6; i++) send_beat(mk(6, i), 16'hFFFF, i == 6);
    @(negedge clk);
    check("resync_len", len_a, 32'd3);
    check("resync_valid", valid_a, 1'b1);
    ack();

    // Partial keep on a non-last beat
    send_beat(mk(7, 1), 16'hFFFF, 1'b0);
    send_beat(mk(7, 2), 16'h0FFF, 1'b0);
    send_beat(mk(7, 3), 16'hFFFF, 1'b1);
    @(negedge clk);
    check("keepchk_err", err_a, KEEP_ERR_EXP);
    check("keepchk_len", len_a, 32'd3);
    ack();
    @(negedge clk);
    check("keepchk_err_clr", err_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
